// File: rtl/spi_test_slave.sv
// spi_test_slave: SPI mode-0 slave that emulates an external microphone/ADC.
// The SPI pins are oversampled on clk (at least 8x sck); nothing runs on sck.
// Commands: 0x9F device ID, 0x03 sample stream, 0x02 write step, 0x05 read step.
// Optional: define SPI_TEST_LOOPBACK_EN to add command 0xAA (echo previous byte).
module spi_test_slave #(
    parameter logic [15:0] DEVICE_ID  = 16'hC0DE,
    parameter logic [7:0]  RESET_STEP = 8'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_csb,
    input  logic spi_sck,
    input  logic spi_sdi,
    output logic spi_sdo
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ID     = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_WSTEP  = 3'd4;
    localparam logic [2:0] S_RSTEP  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
`ifdef SPI_TEST_LOOPBACK_EN
    localparam logic [2:0] S_LOOP   = 3'd7;
`endif

    // [0]/[1] form the synchroniser, [2] is the history flop for edge detection
    logic [2:0]  csb_s, sck_s;
    logic [1:0]  sdi_s;

    logic [2:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift, tx_shift;
    logic [15:0] sample_cnt;
    logic [7:0]  step;
    logic        phase;     // ID: low byte already loaded; SAMPLE: low byte in flight
    logic        lockout;   // set by reset, cleared once csb is seen high

    logic        csb_rise, csb_fall, sck_rise, sck_fall;
    logic [7:0]  rx_next;
    logic [15:0] sample_next;

    // Pin synchronisers; left unreset so they track the pins through reset
    always_ff @(posedge clk) begin
        csb_s <= {csb_s[1:0], spi_csb};
        sck_s <= {sck_s[1:0], spi_sck};
        sdi_s <= {sdi_s[0], spi_sdi};
    end

    // Edge detects, next receive byte and next sample value
    always_comb begin
        csb_rise    =  csb_s[1] & ~csb_s[2];
        csb_fall    = ~csb_s[1] &  csb_s[2];
        sck_rise    =  sck_s[1] & ~sck_s[2];
        sck_fall    = ~sck_s[1] &  sck_s[2];
        rx_next     = {rx_shift[6:0], sdi_s[1]};
        sample_next = sample_cnt + {8'h00, step};
    end

    // Transaction FSM, shift registers and sample counter
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_sdo    <= 1'b0;
            sample_cnt <= 16'h0000;
            step       <= RESET_STEP;
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            phase      <= 1'b0;
            lockout    <= 1'b1;
        end else begin
            if (csb_s[1])
                lockout <= 1'b0;

            if (csb_rise) begin
                // end of transaction wins over any coincident sck edge
                state    <= S_IDLE;
                spi_sdo  <= 1'b0;
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
                tx_shift <= 8'h00;
            end else if (csb_fall && !lockout) begin
                state    <= S_CMD;
                spi_sdo  <= 1'b0;
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
                tx_shift <= 8'h00;
                phase    <= 1'b0;
            end else if (state != S_IDLE) begin
                if (sck_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // byte boundary: load the next response byte
                        case (state)
                            S_CMD: begin
                                phase <= 1'b0;
                                case (rx_next)
                                    8'h9F: begin state <= S_ID;     tx_shift <= DEVICE_ID[15:8]; end
                                    8'h03: begin state <= S_SAMPLE; tx_shift <= sample_cnt[15:8]; end
                                    8'h02: begin state <= S_WSTEP;  tx_shift <= 8'h00; end
                                    8'h05: begin state <= S_RSTEP;  tx_shift <= step; end
`ifdef SPI_TEST_LOOPBACK_EN
                                    8'hAA: begin state <= S_LOOP;   tx_shift <= 8'h00; end
`endif
                                    default: begin state <= S_DONE; tx_shift <= 8'h00; end
                                endcase
                            end
                            S_ID: begin
                                tx_shift <= phase ? 8'h00 : DEVICE_ID[7:0];
                                phase    <= 1'b1;
                            end
                            S_SAMPLE: begin
                                if (!phase) begin
                                    tx_shift <= sample_cnt[7:0];
                                    phase    <= 1'b1;
                                end else begin
                                    // whole sample has been shifted out
                                    sample_cnt <= sample_next;
                                    tx_shift   <= sample_next[15:8];
                                    phase      <= 1'b0;
                                end
                            end
                            S_WSTEP: begin
                                step     <= rx_next;
                                state    <= S_DONE;
                                tx_shift <= 8'h00;
                            end
                            S_RSTEP: tx_shift <= step;
`ifdef SPI_TEST_LOOPBACK_EN
                            S_LOOP:  tx_shift <= rx_next;
`endif
                            default: tx_shift <= 8'h00;
                        endcase
                    end
                end else if (sck_fall) begin
                    spi_sdo  <= (state == S_CMD || state == S_DONE) ? 1'b0 : tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_test_slave.sv
// tb_spi_test_slave: directed bench for spi_test_slave with a byte scoreboard
// and a small model of the sample counter / step register.
module tb_spi_test_slave;

    localparam int HALF = 4;   // sck half period in clk cycles (sck = clk/8)

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_csb = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_sdi = 1'b0;
    logic spi_sdo;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  sb[$];
    logic [15:0] model_cnt  = 16'h0000;
    logic [7:0]  model_step = 8'd1;

    spi_test_slave dut (
        .clk     (clk),
        .reset   (reset),
        .spi_csb (spi_csb),
        .spi_sck (spi_sck),
        .spi_sdi (spi_sdi),
        .spi_sdo (spi_sdo)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_clk(4);
        reset = 1'b0;
        model_cnt  = 16'h0000;
        model_step = 8'd1;
        wait_clk(2);
    endtask

    task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) begin
            spi_sdi = mosi[i];
            wait_clk(HALF);
            miso[i] = spi_sdo;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_csb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        spi_csb = 1'b1;
        wait_clk(8);
        check("sdo_after_csb_high", {15'h0, spi_sdo}, 16'h0000);
    endtask

    // push the expected response, transfer one byte, pop and compare
    task automatic xfer(input string tag, input logic [7:0] mosi, input logic [7:0] exp);
        logic [7:0] got;
        logic [7:0] e;
        sb.push_back(exp);
        spi_byte(mosi, got);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            e = sb.pop_front();
            check(tag, {8'h00, got}, {8'h00, e});
        end
    endtask

    task automatic read_samples(input int n);
        cs_low();
        xfer("sample_cmd", 8'h03, 8'h00);
        for (int k = 0; k < n; k++) begin
            xfer("sample_hi", 8'h00, model_cnt[15:8]);
            xfer("sample_lo", 8'h00, model_cnt[7:0]);
            model_cnt = model_cnt + {8'h00, model_step};
        end
        cs_high();
    endtask

    task automatic write_step(input logic [7:0] v);
        cs_low();
        xfer("wstep_cmd", 8'h02, 8'h00);
        xfer("wstep_data", v, 8'h00);
        cs_high();
        model_step = v;
    endtask

    initial begin
        logic [7:0] junk;

        // reset state
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        check("reset_sdo", {15'h0, spi_sdo}, 16'h0000);

        // device ID, then zeros
        cs_low();
        xfer("id_cmd", 8'h9F, 8'h00);
        xfer("id_hi", 8'h00, 8'hC0);
        xfer("id_lo", 8'h00, 8'hDE);
        xfer("id_pad", 8'h00, 8'h00);
        cs_high();

        // sample stream; counter persists across transactions
        read_samples(2);
        read_samples(1);

        // step write / readback, then stepped samples from a fresh counter
        do_reset();
        write_step(8'h10);
        cs_low();
        xfer("rstep_cmd", 8'h05, 8'h00);
        xfer("rstep_0", 8'h00, 8'h10);
        xfer("rstep_1", 8'h00, 8'h10);
        cs_high();
        read_samples(2);

        // abort after the high byte: counter must not advance
        do_reset();
        cs_low();
        xfer("abort_cmd", 8'h03, 8'h00);
        xfer("abort_hi", 8'h00, model_cnt[15:8]);
        cs_high();
        read_samples(1);

        // unknown command: DONE, sdo stays low
        cs_low();
        xfer("unk_cmd", 8'h77, 8'h00);
        xfer("unk_0", 8'hFF, 8'h00);
        cs_high();

        // counter wrap: walk to 0xFFFF with step 0xFF, then step 1
        do_reset();
        write_step(8'hFF);
        read_samples(257);
        check("wrap_model_at_ffff", model_cnt, 16'hFFFF);
        write_step(8'h01);
        read_samples(2);

        // reset mid-SAMPLE with csb held low: locked out until csb high
        cs_low();
        xfer("mid_cmd", 8'h03, 8'h00);
        xfer("mid_hi", 8'h00, model_cnt[15:8]);
        do_reset();
        check("mid_reset_sdo", {15'h0, spi_sdo}, 16'h0000);
        spi_byte(8'h9F, junk);
        check("lockout_miso", {8'h00, junk}, 16'h0000);
        spi_byte(8'h00, junk);
        check("lockout_miso2", {8'h00, junk}, 16'h0000);
        cs_high();
        cs_low();
        xfer("post_lock_cmd", 8'h9F, 8'h00);
        xfer("post_lock_id", 8'h00, 8'hC0);
        cs_high();

        // loopback command
        cs_low();
        xfer("loop_cmd", 8'hAA, 8'h00);
        xfer("loop_0", 8'h5A, 8'h00);
`ifdef SPI_TEST_LOOPBACK_EN
        xfer("loop_1", 8'h3C, 8'h5A);
        xfer("loop_2", 8'h00, 8'h3C);
`else
        xfer("loop_1", 8'h3C, 8'h00);
        xfer("loop_2", 8'h00, 8'h00);
`endif
        cs_high();

        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_test_slave.md
Name: spi_test_slave

Overview:
- SPI mode-0 slave test peripheral that emulates an external microphone/ADC on the SoC's SPI master pins (csb/sck/sdi/sdo).
- SPI pins are oversampled by a single system clock; no logic runs on the SPI clock.
- Decodes a one-byte command, then streams an ID, a sample counter or a register value, or accepts a register write.
- Used as a verification target for the SoC SPI master and its interrupt-driven firmware.

Parameters:
- DEVICE_ID, 16'hC0DE, two-byte identity returned by the 0x9F command, MSB first.
- RESET_STEP, 8'd1, reset value of the sample step register.

Ports:
- clk  input  1  system clock; must be at least 8x the SPI sck frequency.
- reset  input  1  synchronous, active-high reset.
- spi_csb  input  1  chip select, active low.
- spi_sck  input  1  SPI clock, mode 0 (idle low).
- spi_sdi  input  1  master-out data to this slave.
- spi_sdo  output  1  slave-out data; always driven, never tristated.

Behaviour:
- Synchronisation:
  - spi_csb, spi_sck and spi_sdi each pass through 2-flop synchronisers, plus one history flop for edge detection.
  - An sck or csb pin edge is acted on exactly 3 clk cycles later.
- Reset values: spi_sdo=0, sample counter=16'h0000, step=RESET_STEP, state=IDLE, bit counter=0, shift registers=0.
- Reset lockout: if synchronised csb is low when reset releases, the slave ignores that transaction until it sees csb high.
- States: IDLE, CMD, ID, SAMPLE, WSTEP, RSTEP, DONE.
- Synchronised csb falling edge: IDLE->CMD, bit counter=0, spi_sdo=0.
- Synchronised csb rising edge, any state: ->IDLE and spi_sdo=0. Any partial byte is discarded. A partial sample does not advance the counter.
- Bit transfer:
  - sck rising edge: shift sdi into rx_shift, MSB first, and increment the 3-bit bit counter.
  - sck falling edge: shift tx_shift out, MSB first, onto spi_sdo.
- Byte boundary (8th rising edge): the next response byte is loaded into tx_shift. Its MSB appears on spi_sdo at the following sck falling edge, so it is valid before the next rising edge.
- Command decode (byte received in CMD):
  - 0x9F -> ID: returns DEVICE_ID[15:8], then DEVICE_ID[7:0], then 8'h00 for the rest of the transaction.
  - 0x03 -> SAMPLE: streams counter[15:8], counter[7:0], repeating.
    - After each complete 16-bit sample is shifted out, counter <= counter + step, zero-extended, modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
    - The counter persists across transactions.
  - 0x02 -> WSTEP: the next full byte received is written to step; state then DONE. A step of 0 is legal (counter frozen).
  - 0x05 -> RSTEP: returns step on every byte, repeating.
  - Any other command -> DONE.
- DONE: spi_sdo=0; received bytes are ignored until csb rises.
- spi_sdo is 0 in IDLE, CMD and DONE, and during the command byte.
- Simultaneous events:
  - csb rising in the same cycle as an sck edge: the csb edge wins.
  - reset overrides everything.

Optional Feature:
- Macro SPI_TEST_LOOPBACK_EN.
- Defined: command 0xAA enters LOOP state. Each response byte equals the byte previously received in that transaction; the first response byte is 8'h00.
- Undefined: 0xAA is an unknown command (DONE, spi_sdo=0), and no LOOP state logic exists.

Test Plan:
- Reset, csb low, send 0x9F + 3 dummy bytes -> sdo bytes 0xC0, 0xDE, 0x00; csb high -> sdo=0.
- After reset, send 0x03 + 4 dummy bytes -> 0x00,0x00,0x00,0x01. A second transaction with 0x03 + 2 bytes -> 0x00,0x02.
- Send 0x02, 0x10; then 0x05 + 1 byte -> 0x10. Then 0x03 + 4 bytes, continuing from counter 0x0000 after reset -> 0x00,0x00,0x00,0x10.
- Abort: 0x03 + 1 byte, csb high, then 0x03 + 2 bytes -> 0x00,0x00 (counter not advanced). Wrap: step 0x01, preload to 0xFFFF via reads -> next sample 0x0000.
- Assert reset mid-SAMPLE with csb held low -> sdo=0; further sck ignored until csb high; next 0x9F returns 0xC0.
- With SPI_TEST_LOOPBACK_EN: send 0xAA, 0x5A, 0x3C -> sdo 0x00, 0x5A. Without the macro -> 0x00, 0x00.
